// File: rtl/uart_xcvr.sv
`default_nettype none
// ============================================================================
// Module   : uart_xcvr
// Purpose  : Full-duplex UART. The TX takes bytes over valid/ready. The RX samples
//            mid-bit from an oversampled tick and checks parity and framing.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xcvr #(
  parameter int CLK_HZ     = 40000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 user_clock,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 usb_rs232_txd,
  input  logic                 usb_rs232_rxd,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV   = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_WAIT  = 3'd1;
  localparam logic [2:0] TX_START = 3'd2;
  localparam logic [2:0] TX_DATA  = 3'd3;
  localparam logic [2:0] TX_PAR   = 3'd4;
  localparam logic [2:0] TX_STOP  = 3'd5;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_PAR   = 3'd3;
  localparam logic [2:0] RX_STOP  = 3'd4;
  localparam logic [2:0] RX_BRK   = 3'd5;

  logic [DIV_W-1:0] div_q;
  logic             w_tick;

  assign w_tick = (div_q == DIV_LAST);

  always_ff @(posedge user_clock or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= w_tick ? '0 : div_q + 1'b1;
  end

  // ---------------------------------------------------------------- TX
  logic [2:0]           tx_state_q, tx_state_d;
  logic [OS_W-1:0]      tx_tcnt_q, tx_tcnt_d;
  logic [3:0]           tx_bcnt_q, tx_bcnt_d;
  logic                 tx_scnt_q, tx_scnt_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 w_tx_bit_end;
  logic                 w_tx_line;

  assign w_tx_bit_end = w_tick && (tx_tcnt_q == OS_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_scnt_d  = tx_scnt_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (w_tick && tx_state_q != TX_IDLE && tx_state_q != TX_WAIT)
      tx_tcnt_d = w_tx_bit_end ? '0 : tx_tcnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ (PARITY == 1);
          tx_state_d = TX_WAIT;
        end
      end
      // Hold the line idle until the next shared tick so every bit spans whole ticks.
      TX_WAIT: begin
        if (w_tick) begin
          tx_state_d = TX_START;
          tx_tcnt_d  = '0;
        end
      end
      TX_START: begin
        if (w_tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bcnt_d  = '0;
        end
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_scnt_d  = '0;
          if (tx_bcnt_q == BIT_LAST) tx_state_d = (PARITY != 0) ? TX_PAR : TX_STOP;
          else                       tx_bcnt_d  = tx_bcnt_q + 1'b1;
        end
      end
      TX_PAR: begin
        if (w_tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_scnt_d  = '0;
        end
      end
      TX_STOP: begin
        if (w_tx_bit_end) begin
          if (tx_scnt_q == STOP_LAST) tx_state_d = TX_IDLE;
          else                        tx_scnt_d  = tx_scnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge user_clock or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bcnt_q  <= '0;
      tx_scnt_q  <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bcnt_q  <= tx_bcnt_d;
      tx_scnt_q  <= tx_scnt_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    case (tx_state_q)
      TX_START: w_tx_line = 1'b0;
      TX_DATA:  w_tx_line = tx_shift_q[0];
      TX_PAR:   w_tx_line = tx_par_q;
      default:  w_tx_line = 1'b1;
    endcase
  end

  assign tx_ready      = (tx_state_q == TX_IDLE);
  assign usb_rs232_txd = loopback | w_tx_line;

  // ---------------------------------------------------------------- RX
  logic [1:0]           rx_sync_q;
  logic                 w_rxs;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_tcnt_q, rx_tcnt_d;
  logic [3:0]           rx_bcnt_q, rx_bcnt_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_out_q, rx_perr_out_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 w_rx_sample;

  always_ff @(posedge user_clock or posedge rst) begin
    if (rst) rx_sync_q <= 2'b11;
    else     rx_sync_q <= {rx_sync_q[0], loopback ? w_tx_line : usb_rs232_rxd};
  end

  assign w_rxs       = rx_sync_q[1];
  assign w_rx_sample = w_tick &&
                       (rx_tcnt_q == ((rx_state_q == RX_START) ? OS_HALF : OS_LAST));

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_tcnt_d     = rx_tcnt_q;
    rx_bcnt_d     = rx_bcnt_q;
    rx_shift_d    = rx_shift_q;
    rx_perr_d     = rx_perr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_perr_out_d = rx_perr_out_q;
    rx_ferr_d     = rx_ferr_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (w_tick && !w_rxs) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
        end
      end
      // After a break, wait for the line to return high before looking for a start edge.
      RX_BRK: begin
        if (w_rxs) rx_state_d = RX_IDLE;
      end
      default: begin
        if (w_tick) rx_tcnt_d = w_rx_sample ? '0 : rx_tcnt_q + 1'b1;
        if (w_rx_sample) begin
          case (rx_state_q)
            RX_START: begin
              rx_bcnt_d  = '0;
              rx_perr_d  = 1'b0;
              rx_state_d = w_rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
              rx_shift_d = {w_rxs, rx_shift_q[DATA_BITS-1:1]};
              if (rx_bcnt_q == BIT_LAST) rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
              else                       rx_bcnt_d  = rx_bcnt_q + 1'b1;
            end
            RX_PAR: begin
              rx_perr_d  = (^rx_shift_q) ^ w_rxs ^ (PARITY == 1);
              rx_state_d = RX_STOP;
            end
            RX_STOP: begin
              rx_valid_d    = 1'b1;
              rx_data_d     = rx_shift_q;
              rx_perr_out_d = (PARITY != 0) && rx_perr_q;
              rx_ferr_d     = !w_rxs;
              rx_state_d    = w_rxs ? RX_IDLE : RX_BRK;
            end
            default: rx_state_d = RX_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge user_clock or posedge rst) begin
    if (rst) begin
      rx_state_q    <= RX_IDLE;
      rx_tcnt_q     <= '0;
      rx_bcnt_q     <= '0;
      rx_shift_q    <= '0;
      rx_perr_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_perr_out_q <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_bcnt_q     <= rx_bcnt_d;
      rx_shift_q    <= rx_shift_d;
      rx_perr_q     <= rx_perr_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_perr_out_q <= rx_perr_out_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_out_q;
  assign rx_frame_err  = rx_ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_xcvr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_xcvr
// Purpose  : Directed bench for uart_xcvr: an 8N1 instance and an 8E1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_xcvr;

  localparam int BIT_CYC = 352;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] tx_data_n = 8'h00, tx_data_e = 8'h00;
  logic       tx_valid_n = 1'b0, tx_valid_e = 1'b0;
  logic       tx_ready_n, tx_ready_e;
  logic       txd_n, txd_e;
  logic       rxd_n = 1'b1, rxd_e = 1'b1;
  logic       lb_n = 1'b0, lb_e = 1'b0;
  logic [7:0] rx_data_n, rx_data_e;
  logic       rx_valid_n, rx_valid_e;
  logic       perr_n, perr_e, ferr_n, ferr_e;

  uart_xcvr u_dut_n (
    .user_clock(clk), .rst(rst),
    .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready_n),
    .usb_rs232_txd(txd_n), .usb_rs232_rxd(rxd_n), .loopback(lb_n),
    .rx_data(rx_data_n), .rx_valid(rx_valid_n),
    .rx_parity_err(perr_n), .rx_frame_err(ferr_n)
  );

  uart_xcvr #(.PARITY(2)) u_dut_e (
    .user_clock(clk), .rst(rst),
    .tx_data(tx_data_e), .tx_valid(tx_valid_e), .tx_ready(tx_ready_e),
    .usb_rs232_txd(txd_e), .usb_rs232_rxd(rxd_e), .loopback(lb_e),
    .rx_data(rx_data_e), .rx_valid(rx_valid_e),
    .rx_parity_err(perr_e), .rx_frame_err(ferr_e)
  );

  always #5 clk = ~clk;

  int         cyc = 0, stb_n = 0, stb_e = 0, low_e = 0;
  logic [7:0] cap_d_n = 8'h00, cap_d_e = 8'h00;
  logic       cap_p_n = 1'b0, cap_f_n = 1'b0, cap_p_e = 1'b0, cap_f_e = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!txd_e) low_e <= low_e + 1;
    if (rx_valid_n) begin
      stb_n <= stb_n + 1; cap_d_n <= rx_data_n; cap_p_n <= perr_n; cap_f_n <= ferr_n;
    end
    if (rx_valid_e) begin
      stb_e <= stb_e + 1; cap_d_e <= rx_data_e; cap_p_e <= perr_e; cap_f_e <= ferr_e;
    end
  end

  int n_cmp = 0, n_err = 0;
  int hs_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rxd_e = v;
    else     rxd_n = v;
  endtask

  task automatic wait_ready(input bit sel, input int max, input string tag);
    int t = 0;
    while (((sel ? tx_ready_e : tx_ready_n) !== 1'b1) && t < max) begin
      hold(1);
      t++;
    end
    chk(tag, sel ? tx_ready_e : tx_ready_n, 1);
  endtask

  task automatic tx_hs(input bit sel, input logic [7:0] d, input bit keep);
    wait_ready(sel, 5000, "tx_ready_before_hs");
    if (sel) begin tx_data_e = d; tx_valid_e = 1'b1; end
    else     begin tx_data_n = d; tx_valid_n = 1'b1; end
    hs_cyc = cyc;
    hold(1);
    if (!keep) begin tx_valid_n = 1'b0; tx_valid_e = 1'b0; end
    chk("tx_ready_low_after_hs", sel ? tx_ready_e : tx_ready_n, 0);
  endtask

  // Bits listed start-bit first (index 0); sampled at two offsets inside each bit.
  task automatic tx_bits(input logic [19:0] bits, input int nb, input int off_a,
                         input int off_b, input string tag);
    int t = 0;
    bit hs = 1'b0;
    while (txd_n !== 1'b0 && t < 1000) begin hold(1); t++; end
    chk("tx_start_seen", txd_n, 0);
    for (int c = 0; c < nb * BIT_CYC; c++) begin
      if ((c % BIT_CYC) == off_a || (c % BIT_CYC) == off_b)
        chk(tag, txd_n, bits[c / BIT_CYC]);
      if (tx_valid_n) begin
        if (tx_ready_n) hs = 1'b1;
        else if (hs)    tx_valid_n = 1'b0;
      end
      hold(1);
    end
  endtask

  task automatic rx_frame(input bit sel, input logic [7:0] d, input bit has_par,
                          input logic pbit, input logic stopv, input int nb_max);
    logic [10:0] fr;
    int nb;
    fr = 11'h7FF;
    fr[0]   = 1'b0;
    fr[8:1] = d;
    if (has_par) begin fr[9] = pbit; fr[10] = stopv; nb = 11; end
    else         begin fr[9] = stopv; nb = 10; end
    for (int i = 0; i < nb && i < nb_max; i++) begin
      set_rx(sel, fr[i]);
      hold(BIT_CYC);
    end
    if (nb_max >= nb) set_rx(sel, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, l0, lat;
    hold(5);
    chk("rst_txd_n", txd_n, 1);
    chk("rst_ready_n", tx_ready_n, 1);
    chk("rst_rxvalid_n", rx_valid_n, 0);
    chk("rst_rxdata_n", rx_data_n, 0);
    chk("rst_errs_n", {perr_n, ferr_n}, 0);
    chk("rst_txd_e", txd_e, 1);
    chk("rst_rxdata_e", rx_data_e, 0);
    rst = 1'b0;
    hold(3);

    // 1: 0x41, 8N1, strict bit timing
    tx_hs(0, 8'h41, 0);
    tx_bits(20'(10'b1010000010), 10, 8, 344, "t1_txd_41");
    wait_ready(0, 200, "t1_ready_back");
    lat = cyc - hs_cyc - 1;
    chk("t1_ready_latency_in_3520_3542", (lat >= 3520 && lat <= 3542), 1);
    hold(50);

    // 2: back-to-back 0x55 then 0xAA with tx_valid held
    tx_hs(0, 8'h55, 1);
    tx_data_n = 8'hAA;
    tx_bits({10'b1101010100, 10'b1010101010}, 20, 176, 176, "t2_txd_b2b");
    chk("t2_valid_dropped", tx_valid_n, 0);
    wait_ready(0, 500, "t2_ready_back");
    hold(50);

    // 3: 8E1 loopback 0xC3
    lb_e = 1'b1;
    s0 = stb_e; l0 = low_e;
    hold(2);
    tx_hs(1, 8'hC3, 0);
    wait_ready(1, 5000, "t3_ready_back");
    hold(50);
    chk("t3_strobes", stb_e - s0, 1);
    chk("t3_rxdata", cap_d_e, 8'hC3);
    chk("t3_perr", cap_p_e, 0);
    chk("t3_ferr", cap_f_e, 0);
    chk("t3_pin_low_cycles", low_e - l0, 0);
    lb_e = 1'b0;
    hold(50);

    // 4: 8E1 frames: wrong parity, then stop bit low
    s0 = stb_e;
    rx_frame(1, 8'h3C, 1, 1'b1, 1'b1, 99);
    hold(100);
    chk("t4_strobes_a", stb_e - s0, 1);
    chk("t4_rxdata_a", cap_d_e, 8'h3C);
    chk("t4_perr_a", cap_p_e, 1);
    chk("t4_ferr_a", cap_f_e, 0);
    rx_frame(1, 8'h3C, 1, 1'b0, 1'b0, 99);
    hold(400);
    chk("t4_strobes_b", stb_e - s0, 2);
    chk("t4_rxdata_b", cap_d_e, 8'h3C);
    chk("t4_perr_b", cap_p_e, 0);
    chk("t4_ferr_b", cap_f_e, 1);

    // 5: 100-cycle glitch is a false start, then 0x7E
    s0 = stb_n;
    rxd_n = 1'b0;
    hold(100);
    rxd_n = 1'b1;
    hold(800);
    chk("t5_no_strobe_glitch", stb_n - s0, 0);
    rx_frame(0, 8'h7E, 0, 1'b0, 1'b1, 99);
    hold(100);
    chk("t5_strobes", stb_n - s0, 1);
    chk("t5_rxdata", cap_d_n, 8'h7E);
    chk("t5_errs", {cap_p_n, cap_f_n}, 0);

    // 6: reset mid TX (data bit 4 of 0x4A is low) and mid RX
    tx_hs(0, 8'h4A, 0);
    hold(1000);
    rx_frame(0, 8'hA5, 0, 1'b0, 1'b1, 3);
    chk("t6_txd_low_mid_frame", txd_n, 0);
    s0 = stb_n;
    rst = 1'b1;
    #1;
    chk("t6_rst_txd", txd_n, 1);
    chk("t6_rst_ready", tx_ready_n, 1);
    chk("t6_rst_rxvalid", rx_valid_n, 0);
    chk("t6_rst_rxdata", rx_data_n, 0);
    rxd_n = 1'b1;
    hold(5);
    rst = 1'b0;
    hold(4000);
    chk("t6_no_strobe", stb_n - s0, 0);
    chk("t6_txd_idle", txd_n, 1);
    tx_hs(0, 8'h12, 0);
    tx_bits(20'(10'b1000100100), 10, 176, 176, "t6_txd_12");
    wait_ready(0, 500, "t6_ready_back");
    rx_frame(0, 8'h12, 0, 1'b0, 1'b1, 99);
    hold(100);
    chk("t6_strobes", stb_n - s0, 1);
    chk("t6_rxdata", cap_d_n, 8'h12);
    chk("t6_errs", {cap_p_n, cap_f_n}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
